gpu_blit: RTL

Parametrised CHIP-8-family sprite engine and next-generation framebuffer drawer. Takes CLEAR and DRAW commands from the CPU core and performs XOR sprite blits into a byte-packed, memory-resident framebuffer of configurable size. Supports per-command clip or wrap at screen edges and reports pixel collision. Sits between the CPU command interface and the shared RAM read/write ports.

---
 rtl/gpu_pkg.sv | 19 +
 rtl/gpu_blit_if.sv | 37 +++
 rtl/gpu_row_merge.sv | 19 +
 rtl/gpu_blit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared command codes and controller state encoding for the sprite blitter.
package gpu_pkg;

    localparam logic [3:0] CMD_CLEAR = 4'd0;
    localparam logic [3:0] CMD_DRAW  = 4'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ROW,
        ST_RD_SPR,
        ST_RD_L,
        ST_WR_L,
        ST_RD_R,
        ST_WR_R,
        ST_FIN
    } state_t;

endpackage

// File: rtl/gpu_blit_if.sv
// Command bundle from the CPU plus the shared RAM read/write ports.
// The blitter connects to the slave modport; the CPU/RAM side uses master.
interface gpu_blit_if #(
    parameter int ADDR_W = 12
);
    logic [3:0]        cmd;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] draw_offset;
    logic [3:0]        draw_len;
    logic [7:0]        draw_x;
    logic [7:0]        draw_y;
    logic              wrap_en;
    logic              collision;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_rd_ack;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wr_data;

    modport master (
        output cmd, cmd_valid, draw_offset, draw_len, draw_x, draw_y, wrap_en,
        output mem_rd_data, mem_rd_ack,
        input  cmd_ready, collision, done,
        input  mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  cmd, cmd_valid, draw_offset, draw_len, draw_x, draw_y, wrap_en,
        input  mem_rd_data, mem_rd_ack,
        output cmd_ready, collision, done,
        output mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/gpu_row_merge.sv
// Combinational XOR merge of one shifted sprite byte into a framebuffer byte.
module gpu_row_merge (
    input  logic [7:0] spr_i,
    input  logic [2:0] shift_i,
    input  logic [7:0] old_i,
    input  logic       right_i,
    output logic [7:0] new_o,
    output logic       coll_o
);
    logic [15:0] spread;
    logic [7:0]  part;

    // Upper byte of the spread is the left-column part, lower byte the spill-over.
    assign spread = {spr_i, 8'h00} >> shift_i;
    assign part   = right_i ? spread[7:0] : spread[15:8];
    assign new_o  = old_i ^ part;
    assign coll_o = |(old_i & part);

endmodule

// File: rtl/gpu_blit.sv
// CHIP-8 style sprite engine: CLEAR and XOR DRAW into a byte-packed framebuffer
// held in shared RAM, with per-command clip/wrap and collision reporting.
module gpu_blit
    import gpu_pkg::*;
#(
    parameter int FB_W    = 64,
    parameter int FB_H    = 32,
    parameter int ADDR_W  = 12,
    parameter int FB_BASE = 'h100
) (
    input logic       clk,
    input logic       rst_n,
    gpu_blit_if.slave bus
);
    localparam int BPR = FB_W / 8;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_BASE + FB_H * BPR - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] offset_q, rowBase_q, rdAddr_q, wrAddr_q;
    logic [3:0]        len_q, row_q;
    logic [7:0]        x0_q, y0_q, spr_q, wrData_q;
    logic              wrap_q, rd_q, wr_q, ready_q, done_q, coll_q;

    logic [8:0]        yrRaw, yrWrap;
    logic              rowClipped;
    logic [5:0]        colL, colRRaw, colR;
    logic              rightHit, needRight;
    logic [ADDR_W-1:0] leftAddr, rightAddr;
    logic [7:0]        mergeByte;
    logic              mergeColl, ackNow;

    // Screen row of the current sprite row; clipping ends the draw, wrapping folds it.
    assign yrRaw      = 9'(y0_q) + 9'(row_q);
    assign yrWrap     = 9'(int'(yrRaw) % FB_H);
    assign rowClipped = !wrap_q && (int'(yrRaw) >= FB_H);

    assign colL      = {1'b0, x0_q[7:3]};
    assign colRRaw   = colL + 6'd1;
    assign rightHit  = (colRRaw == 6'(BPR));
    assign colR      = rightHit ? 6'd0 : colRRaw;
    assign needRight = (x0_q[2:0] != 3'd0) && (!rightHit || wrap_q);
    assign leftAddr  = rowBase_q + ADDR_W'(colL);
    assign rightAddr = rowBase_q + ADDR_W'(colR);

    assign ackNow = rd_q && bus.mem_rd_ack;

    gpu_row_merge u_merge (
        .spr_i   (spr_q),
        .shift_i (x0_q[2:0]),
        .old_i   (bus.mem_rd_data),
        .right_i (state_q == ST_RD_R),
        .new_o   (mergeByte),
        .coll_o  (mergeColl)
    );

    // Single controller: every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            offset_q  <= '0;
            rowBase_q <= '0;
            rdAddr_q  <= '0;
            wrAddr_q  <= '0;
            len_q     <= '0;
            row_q     <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            spr_q     <= '0;
            wrData_q  <= '0;
            wrap_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        ready_q  <= 1'b0;
                        offset_q <= bus.draw_offset;
                        len_q    <= bus.draw_len;
                        x0_q     <= 8'(int'(bus.draw_x) % FB_W);
                        y0_q     <= 8'(int'(bus.draw_y) % FB_H);
                        wrap_q   <= bus.wrap_en;
                        row_q    <= '0;
                        case (bus.cmd)
                            CMD_CLEAR: begin
                                wr_q     <= 1'b1;
                                wrAddr_q <= ADDR_W'(FB_BASE);
                                wrData_q <= 8'h00;
                                state_q  <= ST_CLEAR;
                            end
                            CMD_DRAW: begin
                                coll_q <= 1'b0;
                                if (bus.draw_len == 4'd0) begin
                                    done_q  <= 1'b1;
                                    state_q <= ST_FIN;
                                end else begin
                                    state_q <= ST_ROW;
                                end
                            end
                            default: begin
                                done_q  <= 1'b1;
                                state_q <= ST_FIN;
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    if (wrAddr_q == CLR_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        wr_q     <= 1'b1;
                        wrAddr_q <= wrAddr_q + 1'b1;
                    end
                end
                ST_ROW: begin
                    if (row_q == len_q || rowClipped) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        rowBase_q <= ADDR_W'(FB_BASE + int'(yrWrap) * BPR);
                        rd_q      <= 1'b1;
                        rdAddr_q  <= offset_q + ADDR_W'(row_q);
                        state_q   <= ST_RD_SPR;
                    end
                end
                ST_RD_SPR: begin
                    if (ackNow) begin
                        spr_q   <= bus.mem_rd_data;
                        rd_q    <= 1'b0;
                        state_q <= ST_RD_L;
                    end
                end
                // First cycle here is the mandatory gap between reads; then issue and wait.
                ST_RD_L: begin
                    if (!rd_q) begin
                        rd_q     <= 1'b1;
                        rdAddr_q <= leftAddr;
                    end else if (ackNow) begin
                        rd_q     <= 1'b0;
                        wr_q     <= 1'b1;
                        wrAddr_q <= leftAddr;
                        wrData_q <= mergeByte;
                        coll_q   <= coll_q | mergeColl;
                        state_q  <= ST_WR_L;
                    end
                end
                ST_WR_L: begin
                    if (needRight) begin
                        rd_q     <= 1'b1;
                        rdAddr_q <= rightAddr;
                        state_q  <= ST_RD_R;
                    end else begin
                        row_q   <= row_q + 4'd1;
                        state_q <= ST_ROW;
                    end
                end
                ST_RD_R: begin
                    if (ackNow) begin
                        rd_q     <= 1'b0;
                        wr_q     <= 1'b1;
                        wrAddr_q <= rightAddr;
                        wrData_q <= mergeByte;
                        coll_q   <= coll_q | mergeColl;
                        state_q  <= ST_WR_R;
                    end
                end
                ST_WR_R: begin
                    row_q   <= row_q + 4'd1;
                    state_q <= ST_ROW;
                end
                ST_FIN: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.collision   = coll_q;
    assign bus.done        = done_q;
    assign bus.mem_rd      = rd_q;
    assign bus.mem_rd_addr = rdAddr_q;
    assign bus.mem_wr      = wr_q;
    assign bus.mem_wr_addr = wrAddr_q;
    assign bus.mem_wr_data = wrData_q;

endmodule
